// File: rtl/reg_file_pkg.sv
// Shared sizing constants and types for the 8x16 operand register file.
// Latency: n/a. Backpressure: n/a.
package reg_file_pkg;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef logic [WIDTH-1:0]  reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_rd_port.sv
// DEPTH:1 read mux for one register file port; REG_FILE_BYPASS_EN adds write-through forwarding.
// Latency: 0 cycles (combinational). Backpressure: none.
module reg_file_rd_port
    import reg_file_pkg::*;
(
    input  reg_data_t [DEPTH-1:0] regs_i,
    input  reg_addr_t             rd_addr_i,
`ifdef REG_FILE_BYPASS_EN
    input  logic                  wr_i,
    input  reg_addr_t             wr_addr_i,
    input  reg_data_t             wr_dat_i,
`endif
    output reg_data_t             d_out_o
);

    always_comb begin
        d_out_o = regs_i[rd_addr_i];
`ifdef REG_FILE_BYPASS_EN
        // Forward the in-flight write so decode sees it in the same cycle.
        if (wr_i && (rd_addr_i == wr_addr_i)) begin
            d_out_o = wr_dat_i;
        end
`endif
    end

endmodule

// File: rtl/reg_file.sv
// 8x16 register file, two combinational read ports, one synchronous write port (optional REG_FILE_BYPASS_EN).
// Latency: write 1 cycle, read 0 cycles. Backpressure: none; a write occurs every cycle wr is high.
module reg_file
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  d_in,
    output logic [WIDTH-1:0]  d_out_a,
    output logic [WIDTH-1:0]  d_out_b
);

    reg_data_t [DEPTH-1:0] regs_q;
    reg_data_t [DEPTH-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (wr) begin
            regs_d[wr_addr] = d_in;
        end
    end

    // reset is active-low; asserting it clears every register without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_file_rd_port u_rd_port_a (
        .regs_i    (regs_q),
        .rd_addr_i (rd_addr_a),
`ifdef REG_FILE_BYPASS_EN
        .wr_i      (wr),
        .wr_addr_i (wr_addr),
        .wr_dat_i  (d_in),
`endif
        .d_out_o   (d_out_a)
    );

    reg_file_rd_port u_rd_port_b (
        .regs_i    (regs_q),
        .rd_addr_i (rd_addr_b),
`ifdef REG_FILE_BYPASS_EN
        .wr_i      (wr),
        .wr_addr_i (wr_addr),
        .wr_dat_i  (d_in),
`endif
        .d_out_o   (d_out_b)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations adapt to REG_FILE_BYPASS_EN.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic        wr;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
    logic [15:0] d_out_a;
    logic [15:0] d_out_b;

    int tests;
    int fails;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_file dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        wr = 1'b0;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        wr_addr = 3'd0;
        d_in = 16'h0000;

        // Reset sweep: every register reads zero on both ports.
        #2;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            #1;
            check("reset_a", d_out_a, 16'h0000);
            check("reset_b", d_out_b, 16'h0000);
        end
        @(negedge clk);
        reset = 1'b1;

        // Basic writes r3, r7.
        @(negedge clk);
        wr = 1'b1; wr_addr = 3'd3; d_in = 16'hcdef;
        @(negedge clk);
        wr_addr = 3'd7; d_in = 16'h3210;
        @(negedge clk);
        wr = 1'b0; rd_addr_a = 3'd3; rd_addr_b = 3'd7;
        #1;
        check("wr_r3", d_out_a, 16'hcdef);
        check("wr_r7", d_out_b, 16'h3210);

        // Dual read with concurrent write to r5.
        @(negedge clk);
        wr = 1'b1; wr_addr = 3'd5; d_in = 16'h4567; rd_addr_a = 3'd3; rd_addr_b = 3'd7;
        #1;
        check("dual_pre_a", d_out_a, 16'hcdef);
        check("dual_pre_b", d_out_b, 16'h3210);
        @(posedge clk);
        #1;
        check("dual_post_a", d_out_a, 16'hcdef);
        check("dual_post_b", d_out_b, 16'h3210);
        @(negedge clk);
        wr = 1'b0; rd_addr_a = 3'd5;
        #1;
        check("r5", d_out_a, 16'h4567);

        // Write r0 while reading an unwritten register.
        @(negedge clk);
        wr = 1'b1; wr_addr = 3'd0; d_in = 16'hba98; rd_addr_a = 3'd1; rd_addr_b = 3'd5;
        #1;
        check("r0wr_a", d_out_a, 16'h0000);
        check("r0wr_b", d_out_b, 16'h4567);
        @(negedge clk);
        wr = 1'b0; rd_addr_a = 3'd0;
        #1;
        check("r0", d_out_a, 16'hba98);

        // Write disabled: r1 unaffected.
        @(negedge clk);
        wr = 1'b0; wr_addr = 3'd1; d_in = 16'hffff; rd_addr_a = 3'd1;
        @(posedge clk);
        #1;
        check("nowr_r1", d_out_a, 16'h0000);
        rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        #1;
        check("nowr_r0_a", d_out_a, 16'hba98);
        check("nowr_r0_b", d_out_b, 16'hba98);

        // Read-during-write on port A.
        @(negedge clk);
        wr = 1'b1; wr_addr = 3'd3; d_in = 16'h1111; rd_addr_a = 3'd3; rd_addr_b = 3'd7;
        #1;
        check("rdw_a_pre", d_out_a, BYP ? 16'h1111 : 16'hcdef);
        check("rdw_b_other", d_out_b, 16'h3210);
        @(posedge clk);
        #1;
        check("rdw_a_post", d_out_a, 16'h1111);
        @(negedge clk);
        wr = 1'b0;
        #1;
        check("rdw_a_hold", d_out_a, 16'h1111);

        // Read-during-write on port B.
        @(negedge clk);
        wr = 1'b1; wr_addr = 3'd7; d_in = 16'h7777; rd_addr_a = 3'd5; rd_addr_b = 3'd7;
        #1;
        check("rdw_b_pre", d_out_b, BYP ? 16'h7777 : 16'h3210);
        check("rdw_b_a_other", d_out_a, 16'h4567);
        @(negedge clk);
        wr = 1'b0;
        #1;
        check("rdw_b_post", d_out_b, 16'h7777);

        // Asynchronous reset mid-run, with a write attempted while held.
        @(negedge clk);
        rd_addr_a = 3'd3; rd_addr_b = 3'd7;
        #2;
        reset = 1'b0;
        #1;
        check("arst_a", d_out_a, 16'h0000);
        check("arst_b", d_out_b, 16'h0000);
        wr = 1'b1; wr_addr = 3'd2; d_in = 16'habcd;
        @(posedge clk);
        #1;
        wr = 1'b0; rd_addr_a = 3'd2;
        #1;
        check("arst_wr_lost", d_out_a, 16'h0000);
        check("arst_r7", d_out_b, 16'h0000);

        // Release and confirm writes resume.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr = 1'b1; wr_addr = 3'd2; d_in = 16'habcd;
        @(negedge clk);
        wr = 1'b0; rd_addr_a = 3'd2; rd_addr_b = 3'd3;
        #1;
        check("post_rst_r2", d_out_a, 16'habcd);
        check("post_rst_r3", d_out_b, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
